// File: rtl/nibble_sort_stream.sv
// Streaming wrapper around a 4x4-bit sorting network: gathers four nibbles, sorts them, drains them in order.
// Optional build macro NIBBLE_SORT_ASCEND_EN switches the drain order from descending to ascending.
module nibble_sort_stream #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_data,
    output logic               out_last,
    output logic [COUNT_W-1:0] groups_done
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [1:0]         slot, slot_d;
    logic [15:0]        gather_p0, gather_d;
    logic [15:0]        result_p1, result_d;
    logic [COUNT_W-1:0] groups_q, groups_d;
    logic               vld_p1;
    logic [1:0]         nib_idx;

    // Compare-exchange that leaves the larger value in hi.
    function automatic logic [7:0] cmp_swap(input logic [3:0] hi, input logic [3:0] lo);
        if (hi >= lo)
            return {hi, lo};
        else
            return {lo, hi};
    endfunction

    // Five-comparator network; result nibble [15:12] holds the maximum, [3:0] the minimum.
    function automatic logic [15:0] sort4(input logic [15:0] w);
        logic [3:0] a0, a1, a2, a3;
        logic [7:0] pr;
        a0 = w[3:0];
        a1 = w[7:4];
        a2 = w[11:8];
        a3 = w[15:12];
        pr = cmp_swap(a0, a1); a0 = pr[7:4]; a1 = pr[3:0];
        pr = cmp_swap(a2, a3); a2 = pr[7:4]; a3 = pr[3:0];
        pr = cmp_swap(a0, a2); a0 = pr[7:4]; a2 = pr[3:0];
        pr = cmp_swap(a1, a3); a1 = pr[7:4]; a3 = pr[3:0];
        pr = cmp_swap(a1, a2); a1 = pr[7:4]; a2 = pr[3:0];
        return {a0, a1, a2, a3};
    endfunction

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= FILL;
            slot      <= 2'd0;
            gather_p0 <= 16'd0;
            result_p1 <= 16'd0;
            groups_q  <= '0;
        end else begin
            state     <= state_d;
            slot      <= slot_d;
            gather_p0 <= gather_d;
            result_p1 <= result_d;
            groups_q  <= groups_d;
        end
    end

    always_comb begin
        state_d  = state;
        slot_d   = slot;
        gather_d = gather_p0;
        result_d = result_p1;
        groups_d = groups_q;
        case (state)
            // Stage p0: gather four nibbles into the sorter input word
            FILL: begin
                if (in_valid) begin
                    gather_d[{slot, 2'b00} +: 4] = in_data;
                    if (slot == 2'd3) begin
                        slot_d  = 2'd0;
                        state_d = SORT;
                    end else begin
                        slot_d = slot + 2'd1;
                    end
                end
            end
            // Stage p1: register the sorter output
            SORT: begin
                result_d = sort4(gather_p0);
                slot_d   = 2'd0;
                state_d  = DRAIN;
            end
            DRAIN: begin
                if (out_ready) begin
                    if (slot == 2'd3) begin
                        slot_d   = 2'd0;
                        state_d  = FILL;
                        groups_d = groups_q + COUNT_W'(1);
                    end else begin
                        slot_d = slot + 2'd1;
                    end
                end
            end
            default: begin
                state_d = FILL;
                slot_d  = 2'd0;
            end
        endcase
    end

`ifdef NIBBLE_SORT_ASCEND_EN
    assign nib_idx = slot;
`else
    assign nib_idx = ~slot;
`endif

    assign vld_p1      = (state == DRAIN);
    assign in_ready    = (state == FILL);
    assign out_valid   = vld_p1;
    assign out_data    = vld_p1 ? result_p1[{nib_idx, 2'b00} +: 4] : 4'd0;
    assign out_last    = vld_p1 && (slot == 2'd3);
    assign groups_done = groups_q;

endmodule

// File: tb/tb_nibble_sort_stream.sv
// Self-checking bench for nibble_sort_stream: directed scenarios plus randomized traffic against a queue-based model.
module tb_nibble_sort_stream;

    logic       clk = 1'b0;
    logic       nrst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_last;
    logic [7:0] groups_done;

    always #5 clk = ~clk;

    nibble_sort_stream #(.COUNT_W(8)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .groups_done(groups_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: nibbles of the current partial group, nibbles still to be emitted,
    // a flag for the single idle sorting cycle, and the completed-group count.
    logic [3:0] gq[$];
    logic [3:0] eq[$];
    bit         sorting;
    int         m_groups;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        gq.delete();
        eq.delete();
        sorting  = 1'b0;
        m_groups = 0;
    endtask

    task automatic model_sort();
        eq.delete();
`ifdef NIBBLE_SORT_ASCEND_EN
        for (int v = 0; v <= 15; v++)
`else
        for (int v = 15; v >= 0; v--)
`endif
            foreach (gq[i])
                if (int'(gq[i]) == v) eq.push_back(gq[i]);
        gq.delete();
    endtask

    task automatic cycle(input logic v, input logic [3:0] d, input logic r, input logic rn);
        logic       exp_rdy;
        logic       exp_vld;
        logic [3:0] exp_d;
        logic       exp_last;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        nrst      = rn;
        #3;
        exp_rdy  = !sorting && (eq.size() == 0);
        exp_vld  = (eq.size() != 0);
        exp_d    = exp_vld ? eq[0] : 4'd0;
        exp_last = (eq.size() == 1);
        check("in_ready",    32'(in_ready),    32'(exp_rdy));
        check("out_valid",   32'(out_valid),   32'(exp_vld));
        check("out_data",    32'(out_data),    32'(exp_d));
        check("out_last",    32'(out_last),    32'(exp_last));
        check("groups_done", 32'(groups_done), 32'(m_groups % 256));
        @(posedge clk);
        #1;
        if (!rn) begin
            model_reset();
        end else if (sorting) begin
            sorting = 1'b0;
            model_sort();
        end else if (eq.size() != 0) begin
            if (r) begin
                void'(eq.pop_front());
                if (eq.size() == 0) m_groups++;
            end
        end else if (v) begin
            gq.push_back(d);
            if (gq.size() == 4) sorting = 1'b1;
        end
    endtask

    task automatic feed4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] e);
        cycle(1'b1, a, 1'b1, 1'b1);
        cycle(1'b1, b, 1'b1, 1'b1);
        cycle(1'b1, c, 1'b1, 1'b1);
        cycle(1'b1, e, 1'b1, 1'b1);
    endtask

    initial begin
        nrst      = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'd0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset held with in_valid asserted: nothing may be gathered.
        cycle(1'b1, 4'h5, 1'b0, 1'b0);
        cycle(1'b1, 4'h6, 1'b0, 1'b0);

        // Basic group.
        feed4(4'h3, 4'h9, 4'h1, 4'h7);
        repeat (6) cycle(1'b0, 4'h0, 1'b1, 1'b1);
        check("basic_groups", 32'(groups_done), 32'd1);

        // Duplicates with a 3-cycle downstream stall at the first drain cycle.
        feed4(4'h5, 4'h5, 4'h0, 4'hF);
        cycle(1'b1, 4'hA, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, 4'hA, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, 4'hA, 1'b1, 1'b1);
        cycle(1'b0, 4'hA, 1'b1, 1'b1);
        cycle(1'b0, 4'h0, 1'b1, 1'b1);
        check("dup_groups", 32'(groups_done), 32'd2);

        // Reset in the middle of a partial group.
        cycle(1'b1, 4'h2, 1'b1, 1'b1);
        cycle(1'b1, 4'h4, 1'b1, 1'b1);
        cycle(1'b1, 4'h9, 1'b1, 1'b0);
        feed4(4'h2, 4'h4, 4'h6, 4'h8);
        repeat (6) cycle(1'b0, 4'h0, 1'b1, 1'b1);
        check("midfill_groups", 32'(groups_done), 32'd1);

        // Random traffic long enough to wrap the 8-bit group counter.
        for (int i = 0; i < 4200; i++)
            cycle(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0), 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++)
            cycle(($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 79) != 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_sort_stream.md
# nibble_sort_stream

Streaming wrapper around the combinational 4×4-bit sorting network `sort`. It gathers four 4-bit values from an upstream valid/ready stream and packs them into the sorter's 16-bit input. It registers the sorted word and drains it downstream as four nibbles, largest first, over a second valid/ready stream. It converts the bare combinational sorter into a pipelined, backpressure-aware stage usable between sequential producers and consumers.

## Interface
- `COUNT_W`, default 8: width of the completed-group counter.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `nrst`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  upstream nibble valid.
- `in_ready`  out  1  block can accept a nibble.
- `in_data`  in  4  upstream nibble.
- `out_valid`  out  1  downstream nibble valid.
- `out_ready`  in  1  downstream can accept.
- `out_data`  out  4  sorted nibble.
- `out_last`  out  1  marks 4th nibble of a group.
- `groups_done`  out  COUNT_W  count of fully drained groups, modulo 2^COUNT_W.

## Operation
- Transfer on either stream occurs when valid and ready are both high at a rising edge.
- States:
  - FILL: `in_ready`=1; slot counter 0..3.
  - SORT: one cycle, both streams idle.
  - DRAIN: `out_valid`=1; slot counter 0..3.
- FILL: the k-th accepted nibble (k=0..3) is written to gather bits [4k+3:4k]. The 4th accept moves the block to SORT and clears the counter.
- SORT: gather register drives `sort.i`; `sort.o` is captured into the result register. The block then moves to DRAIN.
- DRAIN: `out_data` = result[15:12], [11:8], [7:4], [3:0] for slots 0..3, i.e. descending. `out_last`=1 only at slot 3. The counter advances only on an output transfer.
  - On transfer of slot 3, the block returns to FILL and `groups_done` increments, wrapping to 0 after 2^COUNT_W−1.
- Equal values are emitted as duplicates; the order among equal values is unobservable.
- Arithmetic is unsigned 4-bit, inherited from the sorter.

## Timing
- Reset values: state FILL, both counters 0, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `groups_done`=0. Gather and result registers are cleared to 0.
- `in_ready` is 0 in SORT and DRAIN. `in_valid` asserted there is ignored and no data is consumed.
- `out_data` and `out_last` are 0 whenever `out_valid`=0.
- Latency: 4th input accepted at edge N; `out_valid` rises after edge N+1 and the first nibble is transferable at edge N+2.
- Throughput: minimum 9 cycles per group (4 FILL + 1 SORT + 4 DRAIN) with no stalls.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_last` and the state are held stable indefinitely.
- Upstream gaps: `in_valid`=0 in FILL stalls the counter; partial groups are retained indefinitely.
- Reset mid-operation: `nrst`=0 at any edge overrides every transition. A partial group or undrained result is discarded, and all outputs take their reset values after that edge.
- No combinational path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.

## Configuration
- `NIBBLE_SORT_ASCEND_EN`:
  - Defined: DRAIN emits result[3:0], [7:4], [11:8], [15:12] for slots 0..3 (ascending). `out_last` accompanies the largest value.
  - Undefined: descending order as above.
  - Latency, handshakes and counters are identical in both builds.

## Test plan
- Reset: hold `nrst`=0 for 2 cycles with `in_valid`=1 -> `in_ready`=1, `out_valid`=0, `groups_done`=0. No nibble is counted during reset.
- Basic group: inputs 3,9,1,7 back-to-back, `out_ready`=1 -> outputs 9,7,3,1. `out_valid` is first high 2 cycles after accepting 7, `out_last` is on 1, and `groups_done`=1.
- Backpressure and duplicates: inputs 5,5,0,F; drop `out_ready` for 3 cycles at first DRAIN cycle -> F held stable, then F,5,5,0. `in_ready`=0 throughout with `in_valid`=1.
- Reset mid-fill: accept 2 and 4, pulse `nrst`=0, then feed 2,4,6,8 -> outputs 8,6,4,2 only, `groups_done`=1.
- Counter wrap: COUNT_W=2, drain 4 groups of A,B,C,D -> each outputs D,C,B,A; `groups_done` reads 1,2,3,0.
- Ascending build (`NIBBLE_SORT_ASCEND_EN` defined): inputs 3,9,1,7 -> outputs 1,3,7,9 with `out_last` on 9, same latency as the basic-group case.
